ble_command_supervisor: RTL and testbench

BLE_COMMAND_SUPERVISOR -- requirements
Module: ble_command_supervisor

---
 rtl/ble_pkg.sv | 23 ++
 rtl/ble_slew_limiter.sv | 38 +++
 rtl/ble_command_supervisor.sv | 213 +++++++++++++++++++++
 tb/tb_ble_command_supervisor.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ble_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ble_pkg
//  Description : Shared types and command codes for the BLE command
//                supervisor: supervisor state encoding plus arm/disarm bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
package ble_pkg;

    // Supervisor state encoding, visible externally on sup_state
    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_FAILSAFE = 2'd2
    } sup_state_t;

    // Byte that requests arming (motor byte) or MPU init (mpu byte)
    localparam logic [7:0] ARM_CODE    = 8'hA5;
    // Motor byte that releases the supervisor from FAILSAFE
    localparam logic [7:0] DISARM_CODE = 8'h00;

endpackage
`default_nettype wire

// File: rtl/ble_slew_limiter.sv
`default_nettype none
// ============================================================================
//  Module      : ble_slew_limiter
//  Description : One-axis setpoint slew limiter. On each shared tick the
//                setpoint moves one LSB toward the signed target and holds
//                once equal. A unit step toward an in-range target can never
//                leave the 8-bit signed range, so no wrap is possible.
//  Revision    : 1.0 - initial release
// ============================================================================
module ble_slew_limiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [7:0] target,
    output logic [7:0] setpoint
);

    logic signed [7:0] sp_s;
    logic signed [7:0] tgt_s;

    assign sp_s  = $signed(setpoint);
    assign tgt_s = $signed(target);

    // Step the setpoint by one toward the target on every tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            setpoint <= 8'h00;
        end else if (tick) begin
            if (sp_s < tgt_s) begin
                setpoint <= setpoint + 8'h01;
            end else if (sp_s > tgt_s) begin
                setpoint <= setpoint - 8'h01;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ble_command_supervisor.sv
`default_nettype none
// ============================================================================
//  Module      : ble_command_supervisor
//  Description : Supervises BLE command packets for a gimbal/motor controller:
//                arm/disarm/failsafe state machine, link watchdog, gain
//                reload with update pulse, edge-detected MPU init request and
//                slew-limited pitch/yaw setpoints. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module ble_command_supervisor #(
    parameter int         TIMEOUT_CYCLES = 50_000_000,
    parameter int         SLEW_DIV       = 100_000,
    parameter logic [7:0] ARM_CODE       = ble_pkg::ARM_CODE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vector_valid,
    input  logic [7:0] initialize_mpu_motor,
    input  logic [7:0] initialize_mpu,
    input  logic [7:0] ble_set_pitch,
    input  logic [7:0] ble_set_yaw,
    input  logic [7:0] ble_pitch_kP,
    input  logic [7:0] ble_pitch_kI,
    input  logic [7:0] ble_pitch_kD,
    input  logic [7:0] ble_yaw_kP,
    input  logic [7:0] ble_yaw_kI,
    input  logic [7:0] ble_yaw_kD,
    output logic [7:0] pitch_setpoint,
    output logic [7:0] yaw_setpoint,
    output logic [7:0] pitch_kP,
    output logic [7:0] pitch_kI,
    output logic [7:0] pitch_kD,
    output logic [7:0] yaw_kP,
    output logic [7:0] yaw_kI,
    output logic [7:0] yaw_kD,
    output logic       gains_update,
    output logic       mpu_init_req,
    output logic       motor_enable,
    output logic       link_ok,
    output logic [1:0] sup_state
);

    import ble_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DIV_W = $clog2(SLEW_DIV + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(SLEW_DIV - 1);

    sup_state_t       state;
    sup_state_t       state_next;
    logic [CNT_W-1:0] wd_count;
    logic [CNT_W-1:0] wd_next;
    logic [DIV_W-1:0] div_count;
    logic             tick;
    logic [7:0]       target_pitch;
    logic [7:0]       target_yaw;
    logic [7:0]       last_mpu;
    logic             gains_load;

    // Gains are accepted from any packet except while in FAILSAFE
    assign gains_load = vector_valid && (state != ST_FAILSAFE);
    assign sup_state  = state;
    assign tick       = (div_count == DIV_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_DISARMED;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and next watchdog count; a packet clears the
    // watchdog, so it always wins over a coinciding timeout
    always_comb begin
        wd_next    = wd_count;
        state_next = state;
        if (vector_valid) begin
            wd_next = '0;
        end else if (wd_count != TIMEOUT_VAL) begin
            wd_next = wd_count + 1'b1;
        end
        case (state)
            ST_DISARMED: begin
                if (vector_valid && (initialize_mpu_motor == ARM_CODE)) begin
                    state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (vector_valid) begin
                    if (initialize_mpu_motor != ARM_CODE) begin
                        state_next = ST_DISARMED;
                    end
                end else if (wd_next == TIMEOUT_VAL) begin
                    state_next = ST_FAILSAFE;
                end
            end
            ST_FAILSAFE: begin
                if (vector_valid && (initialize_mpu_motor == DISARM_CODE)) begin
                    state_next = ST_DISARMED;
                end
            end
            default: begin
                state_next = ST_DISARMED;
            end
        endcase
    end

    // Watchdog count and link status; the count starts saturated so the
    // link reads down until the first packet arrives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_count <= TIMEOUT_VAL;
            link_ok  <= 1'b0;
        end else begin
            wd_count <= wd_next;
            link_ok  <= (wd_next < TIMEOUT_VAL);
        end
    end

    // Motor enable follows the registered state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            motor_enable <= 1'b0;
        end else begin
            motor_enable <= (state_next == ST_ARMED);
        end
    end

    // Gain reload and its one-cycle update pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pitch_kP     <= 8'h00;
            pitch_kI     <= 8'h00;
            pitch_kD     <= 8'h00;
            yaw_kP       <= 8'h00;
            yaw_kI       <= 8'h00;
            yaw_kD       <= 8'h00;
            gains_update <= 1'b0;
        end else begin
            gains_update <= gains_load;
            if (gains_load) begin
                pitch_kP <= ble_pitch_kP;
                pitch_kI <= ble_pitch_kI;
                pitch_kD <= ble_pitch_kD;
                yaw_kP   <= ble_yaw_kP;
                yaw_kI   <= ble_yaw_kI;
                yaw_kD   <= ble_yaw_kD;
            end
        end
    end

    // MPU init request on a rising edge of the accepted mpu byte vs ARM_CODE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_mpu     <= 8'h00;
            mpu_init_req <= 1'b0;
        end else begin
            mpu_init_req <= 1'b0;
            if (vector_valid) begin
                last_mpu     <= initialize_mpu;
                mpu_init_req <= (initialize_mpu == ARM_CODE) && (last_mpu != ARM_CODE);
            end
        end
    end

    // Targets track packet values only while armed, otherwise pull to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_pitch <= 8'h00;
            target_yaw   <= 8'h00;
        end else if (state_next == ST_ARMED) begin
            if (vector_valid) begin
                target_pitch <= ble_set_pitch;
                target_yaw   <= ble_set_yaw;
            end
        end else begin
            target_pitch <= 8'h00;
            target_yaw   <= 8'h00;
        end
    end

    // Free-running slew divider shared by both axes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_count <= '0;
        end else if (tick) begin
            div_count <= '0;
        end else begin
            div_count <= div_count + 1'b1;
        end
    end

    ble_slew_limiter u_slew_pitch (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .target   (target_pitch),
        .setpoint (pitch_setpoint)
    );

    ble_slew_limiter u_slew_yaw (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .target   (target_yaw),
        .setpoint (yaw_setpoint)
    );

endmodule
`default_nettype wire

// File: tb/tb_ble_command_supervisor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ble_command_supervisor
//  Description : Self-checking bench for ble_command_supervisor with a
//                behavioural reference model and randomized packets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ble_command_supervisor;

    localparam int TO  = 1000;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vv  = 1'b0;
    logic [7:0] motor = 8'h00;
    logic [7:0] mpu   = 8'h00;
    logic [7:0] pitch = 8'h00;
    logic [7:0] yaw   = 8'h00;
    logic [7:0] gin [6];

    logic [7:0] sp_p, sp_y;
    logic [7:0] g_pkp, g_pki, g_pkd, g_ykp, g_yki, g_ykd;
    logic       gupd, mpureq, men, lok;
    logic [1:0] st;

    int tests = 0;
    int fails = 0;

    // reference model state
    int         m_st, m_cnt, m_cyc;
    int         m_sp [2];
    int         m_tgt [2];
    logic [7:0] m_g [6];
    logic [7:0] m_last;
    bit         m_gupd, m_mpu;

    always #5 clk = ~clk;

    ble_command_supervisor #(
        .TIMEOUT_CYCLES (TO),
        .SLEW_DIV       (DIV),
        .ARM_CODE       (8'hA5)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .vector_valid         (vv),
        .initialize_mpu_motor (motor),
        .initialize_mpu       (mpu),
        .ble_set_pitch        (pitch),
        .ble_set_yaw          (yaw),
        .ble_pitch_kP         (gin[0]),
        .ble_pitch_kI         (gin[1]),
        .ble_pitch_kD         (gin[2]),
        .ble_yaw_kP           (gin[3]),
        .ble_yaw_kI           (gin[4]),
        .ble_yaw_kD           (gin[5]),
        .pitch_setpoint       (sp_p),
        .yaw_setpoint         (sp_y),
        .pitch_kP             (g_pkp),
        .pitch_kI             (g_pki),
        .pitch_kD             (g_pkd),
        .yaw_kP               (g_ykp),
        .yaw_kI               (g_yki),
        .yaw_kD               (g_ykd),
        .gains_update         (gupd),
        .mpu_init_req         (mpureq),
        .motor_enable         (men),
        .link_ok              (lok),
        .sup_state            (st)
    );

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_cnt = TO; m_cyc = 0;
        m_sp[0] = 0; m_sp[1] = 0; m_tgt[0] = 0; m_tgt[1] = 0;
        for (int i = 0; i < 6; i++) m_g[i] = 8'h00;
        m_last = 8'h00; m_gupd = 0; m_mpu = 0;
    endtask

    // Model of one clock edge, computed from the rules with plain integers
    task automatic model_edge();
        bit tick;
        int ncnt, nst;
        tick = ((m_cyc % DIV) == DIV - 1);
        m_cyc++;
        if (tick) begin
            for (int a = 0; a < 2; a++) begin
                if (m_sp[a] < m_tgt[a]) m_sp[a]++;
                else if (m_sp[a] > m_tgt[a]) m_sp[a]--;
            end
        end
        ncnt = vv ? 0 : ((m_cnt < TO) ? m_cnt + 1 : TO);
        nst  = m_st;
        if (m_st == 0 && vv && motor == 8'hA5) nst = 1;
        else if (m_st == 1) begin
            if (vv) begin
                if (motor != 8'hA5) nst = 0;
            end else if (ncnt == TO) nst = 2;
        end else if (m_st == 2 && vv && motor == 8'h00) nst = 0;
        m_gupd = vv && (m_st != 2);
        if (m_gupd) for (int i = 0; i < 6; i++) m_g[i] = gin[i];
        m_mpu = vv && (mpu == 8'hA5) && (m_last != 8'hA5);
        if (vv) m_last = mpu;
        if (nst == 1) begin
            if (vv) begin
                m_tgt[0] = int'($signed(pitch));
                m_tgt[1] = int'($signed(yaw));
            end
        end else begin
            m_tgt[0] = 0; m_tgt[1] = 0;
        end
        m_st = nst; m_cnt = ncnt;
    endtask

    task automatic check_all();
        logic [7:0] g [6];
        g[0] = g_pkp; g[1] = g_pki; g[2] = g_pkd;
        g[3] = g_ykp; g[4] = g_yki; g[5] = g_ykd;
        chk("sup_state", int'(st), m_st);
        chk("motor_enable", int'(men), int'(m_st == 1));
        chk("link_ok", int'(lok), int'(m_cnt < TO));
        chk("mpu_init_req", int'(mpureq), int'(m_mpu));
        chk("gains_update", int'(gupd), int'(m_gupd));
        chk("pitch_setpoint", int'($signed(sp_p)), m_sp[0]);
        chk("yaw_setpoint", int'($signed(sp_y)), m_sp[1]);
        for (int i = 0; i < 6; i++) chk("gain", int'(g[i]), int'(m_g[i]));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic rand_gains();
        for (int i = 0; i < 6; i++) gin[i] = 8'($urandom);
    endtask

    task automatic send(input logic [7:0] mo, input logic [7:0] mp,
                        input logic [7:0] p, input logic [7:0] y);
        motor = mo; mpu = mp; pitch = p; yaw = y; vv = 1'b1;
        cycle();
        vv = 1'b0;
    endtask

    // Idle cycles with a repeat of the last packet every 400 cycles
    task automatic idle_ka(input int n);
        for (int i = 0; i < n; i++) begin
            if (i % 400 == 399) send(motor, mpu, pitch, yaw);
            else cycle();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic async_reset();
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_pitch_zero", int'(sp_p), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        int prev, steps, gap, r;
        for (int i = 0; i < 6; i++) gin[i] = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset_link_ok", int'(lok), 0);
        rst = 1'b0;
        idle(5);

        // Arm with MPU init and pitch +10
        rand_gains();
        send(8'hA5, 8'hA5, 8'd10, 8'($urandom_range(0, 20)));
        chk("arm_state", int'(st), 1);
        chk("arm_motor_enable", int'(men), 1);
        chk("arm_mpu_req", int'(mpureq), 1);
        idle(42);
        chk("pitch_reached_10", int'($signed(sp_p)), 10);

        // Identical packet: no MPU edge, gains still reload
        send(8'hA5, 8'hA5, 8'd10, yaw);
        chk("repeat_mpu_req", int'(mpureq), 0);
        chk("repeat_gains_update", int'(gupd), 1);

        // Packet exactly when the count would reach the timeout
        idle(TO - 1);
        send(8'hA5, 8'hA5, 8'd10, yaw);
        chk("coincide_state", int'(st), 1);
        chk("coincide_link", int'(lok), 1);

        // Timeout to FAILSAFE and slew back to zero
        idle(TO);
        chk("fs_state", int'(st), 2);
        chk("fs_link", int'(lok), 0);
        chk("fs_motor", int'(men), 0);
        idle(60);
        chk("fs_pitch_zero", int'(sp_p), 0);
        rand_gains();
        send(8'hA5, 8'h00, 8'd50, 8'd50);
        chk("fs_gain_ignored", int'(gupd), 0);
        chk("fs_stays", int'(st), 2);
        send(8'h00, 8'h00, 8'd0, 8'd0);
        chk("fs_release", int'(st), 0);

        // Randomized packet traffic
        for (int k = 0; k < 40; k++) begin
            gap = ($urandom_range(0, 9) == 0) ? 1005 : int'($urandom_range(0, 60));
            idle(gap);
            r = int'($urandom_range(0, 3));
            rand_gains();
            send((r < 2) ? 8'hA5 : ((r == 2) ? 8'h00 : 8'($urandom)),
                 ($urandom_range(0, 1) == 1) ? 8'hA5 : 8'($urandom),
                 8'($urandom), 8'($urandom));
        end

        // Full-range slew +127 -> -128 with no wrap
        async_reset();
        send(8'hA5, 8'h00, 8'sd127, 8'h80);
        idle_ka(520);
        chk("pitch_at_127", int'($signed(sp_p)), 127);
        send(8'hA5, 8'h00, 8'h80, 8'sd127);
        steps = 0;
        for (int i = 0; i < 1040; i++) begin
            prev = int'($signed(sp_p));
            if (i % 400 == 399) send(motor, mpu, pitch, yaw);
            else cycle();
            if (int'($signed(sp_p)) != prev) begin
                chk("unit_step", prev - int'($signed(sp_p)), 1);
                steps++;
            end
        end
        chk("step_count", steps, 255);
        chk("pitch_at_m128", int'($signed(sp_p)), -128);

        // Reset in the middle of a slew
        send(8'hA5, 8'h00, 8'sd100, 8'sd100);
        idle(150);
        async_reset();
        idle(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound so the bench always ends
    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
